// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Shared pipeline constants, the MEM/WB control struct and the
//               stage-occupancy state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

    localparam int WORD_LEN        = 32;
    localparam int INSTRUCTION_LEN = 32;

    typedef struct packed {
        logic sel_wb_mem;
        logic sel_wb_alu;
        logic rf_write_en;
    } wb_ctrl_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_t;

endpackage
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// ============================================================================
// Module      : pipe_slot
// Description : One pipeline entry {valid, ctrl, data}; clear wins over load.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_slot #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_ctrl  <= i_ctrl;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_ctrl  = r_ctrl;
    assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_skid
// Description : Valid/ready pipeline stage with a one-entry skid buffer and
//               synchronous flush. Optional stall counter: PIPE_STALL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_skid
    import pipeline_pkg::*;
#(
    parameter int DATA_W = WORD_LEN,
    parameter int CTRL_W = $bits(wb_ctrl_t),
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    stage_state_t      r_state;
    stage_state_t      w_next_state;

    logic              w_main_valid;
    logic [CTRL_W-1:0] w_main_ctrl;
    logic [DATA_W-1:0] w_main_data;
    logic              w_skid_valid;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [DATA_W-1:0] w_skid_data;

    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_main_load;
    logic              w_main_clear;
    logic              w_main_from_skid;
    logic              w_skid_load;
    logic              w_skid_clear;
    logic [CTRL_W-1:0] w_main_d_ctrl;
    logic [DATA_W-1:0] w_main_d_data;

    // in_ready comes from the skid register only, never from out_ready
    assign in_ready   = !w_skid_valid;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = w_main_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_main_load      = 1'b0;
        w_main_clear     = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        w_skid_clear     = 1'b0;
        if (flush) begin
            w_main_clear = 1'b1;
            w_skid_clear = 1'b1;
            w_next_state = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_fire) begin
                        w_main_load  = 1'b1;
                        w_next_state = ONE;
                    end
                end
                ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_load  = 1'b1;
                    end else if (w_out_fire) begin
                        w_main_clear = 1'b1;
                        w_next_state = EMPTY;
                    end else if (w_in_fire) begin
                        w_skid_load  = 1'b1;
                        w_next_state = FULL;
                    end
                end
                FULL: begin
                    if (w_out_fire) begin
                        w_main_load      = 1'b1;
                        w_main_from_skid = 1'b1;
                        w_skid_clear     = 1'b1;
                        w_next_state     = ONE;
                    end
                end
                default: begin
                    w_main_clear = 1'b1;
                    w_skid_clear = 1'b1;
                    w_next_state = EMPTY;
                end
            endcase
        end
    end

    assign w_main_d_ctrl = w_main_from_skid ? w_skid_ctrl : in_ctrl;
    assign w_main_d_data = w_main_from_skid ? w_skid_data : in_data;

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main_slot (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_ctrl  (w_main_d_ctrl),
        .i_data  (w_main_d_data),
        .o_valid (w_main_valid),
        .o_ctrl  (w_main_ctrl),
        .o_data  (w_main_data)
    );

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid_slot (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_ctrl  (in_ctrl),
        .i_data  (in_data),
        .o_valid (w_skid_valid),
        .o_ctrl  (w_skid_ctrl),
        .o_data  (w_skid_data)
    );

    assign out_valid = w_main_valid;
    assign out_data  = w_main_data;
    // Bubbles carry zero control so downstream write enables stay quiet
    assign out_ctrl  = w_main_ctrl & {CTRL_W{w_main_valid}};

`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_main_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_skid
// Description : Directed self-checking bench for pipe_stage_skid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 3;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0]  stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl)
`ifdef PIPE_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++;
        if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
        n_checks++;
        if (out_ctrl !== 3'b000) begin n_fail++; $display("FAIL reset_out_ctrl got %b want 000", out_ctrl); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
`ifdef PIPE_STALL_CNT_EN
        n_checks++;
        if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_stream();
        logic [DATA_W-1:0] vec [3];
        vec[0] = 32'h11; vec[1] = 32'h22; vec[2] = 32'h33;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = vec[i]; in_ctrl = 3'b001;
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== vec[i]) begin
                n_fail++; $display("FAIL stream_data[%0d] got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, vec[i]);
            end
            n_checks++;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d] got %b want 1", i, in_ready); end
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] exp [3];
        exp[0] = 32'hA1; exp[1] = 32'hA2; exp[2] = 32'hA3;
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 3'b010; in_data = 32'hA1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_data !== 32'hA1) begin
            n_fail++; $display("FAIL bp_first got rdy=%b d=%h want rdy=1 d=a1", in_ready, out_data);
        end
        in_data = 32'hA2;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'hA1) begin
            n_fail++; $display("FAIL bp_full got rdy=%b v=%b d=%h want rdy=0 v=1 d=a1", in_ready, out_valid, out_data);
        end
        in_data = 32'hA3;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0 || out_data !== 32'hA1) begin
            n_fail++; $display("FAIL bp_hold got rdy=%b d=%h want rdy=0 d=a1", in_ready, out_data);
        end
        out_ready = 1'b1;
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== exp[i]) begin
                n_fail++; $display("FAIL bp_release[%0d] got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, exp[i]);
            end
        end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_recover got %b want 1", in_ready); end
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 3'b101; in_data = 32'h01;
        @(negedge clk);
        in_data = 32'h02;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_prefill got rdy=%b want 0", in_ready); end
        flush = 1'b1; in_data = 32'hFF; in_ctrl = 3'b111;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || out_ctrl !== 3'b000 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush_full got v=%b c=%b rdy=%b want v=0 c=000 rdy=1", out_valid, out_ctrl, in_ready);
        end
        // flush wins over a same-cycle accept while in ONE
        in_valid = 1'b1; in_data = 32'h55; in_ctrl = 3'b001;
        @(negedge clk);
        flush = 1'b1; in_data = 32'hFF; in_ctrl = 3'b111;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_accept got v=%b d=%h want v=0", out_valid, out_data); end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_never_emit got v=%b d=%h want v=0", out_valid, out_data); end
    endtask

    task automatic test_bubble_mask();
        out_ready = 1'b1; in_valid = 1'b0; in_ctrl = 3'b111; in_data = 32'hDEAD;
        @(negedge clk);
        n_checks++;
        if (out_ctrl !== 3'b000 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bubble_idle got v=%b c=%b want v=0 c=000", out_valid, out_ctrl);
        end
        in_valid = 1'b1; in_ctrl = 3'b101; in_data = 32'h77;
        @(negedge clk);
        n_checks++;
        if (out_ctrl !== 3'b101 || out_data !== 32'h77) begin
            n_fail++; $display("FAIL bubble_valid got c=%b d=%h want c=101 d=77", out_ctrl, out_data);
        end
        in_valid = 1'b0; in_ctrl = 3'b111;
        @(negedge clk);
        n_checks++;
        if (out_ctrl !== 3'b000) begin n_fail++; $display("FAIL bubble_after_pop got c=%b want 000", out_ctrl); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 3'b011; in_data = 32'hB1;
        @(negedge clk);
        in_data = 32'hB2;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL areset_prefill got rdy=%b v=%b want rdy=0 v=1", in_ready, out_valid);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_ctrl !== 3'b000) begin
            n_fail++; $display("FAIL areset_immediate got v=%b rdy=%b c=%b want v=0 rdy=1 c=000", out_valid, in_ready, out_ctrl);
        end
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_no_transfer got v=%b want 0", out_valid); end
    endtask

`ifdef PIPE_STALL_CNT_EN
    task automatic test_stall_cnt();
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 3'b001; in_data = 32'hC1;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL stall_start got %0d want 0", stall_cnt); end
        repeat (3) @(negedge clk);
        n_checks++;
        if (stall_cnt !== 4'd3) begin n_fail++; $display("FAIL stall_count3 got %0d want 3", stall_cnt); end
        repeat (17) @(negedge clk);
        n_checks++;
        if (stall_cnt !== 4'd15) begin n_fail++; $display("FAIL stall_saturate got %0d want 15", stall_cnt); end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_checks++;
        if (stall_cnt !== 4'd15 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL stall_flush got cnt=%0d v=%b want cnt=15 v=0", stall_cnt, out_valid);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_bubble_mask();
        test_async_reset();
`ifdef PIPE_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline-stage register with a valid/ready handshake, a one-entry skid buffer and synchronous flush. It generalises the fixed inter-stage registers (IF/ID … MEM/WB) so that any stage boundary can stall and flush without a combinational ready path across stages. Payload width and control-bit width are parameters. Control bits are forced to zero on bubbles, so downstream write enables never fire on invalid slots.

## Interface
Parameters:
- DATA_W, 32, payload width: data words, e.g. ALU result, memory output, write-back data.
- CTRL_W, 3, control-bit width: write enable, write-back source selects.
- CNT_W, 16, stall-counter width; only used with PIPE_STALL_CNT_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept; driven from registers only.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control bits.
- out_valid  out  1  stage holds a valid entry.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  head payload.
- out_ctrl  out  CTRL_W  head control bits; all zero whenever out_valid=0.
- stall_cnt  out  CNT_W  present only with PIPE_STALL_CNT_EN.

## Operation
- Storage: main slot (drives outputs) and skid slot. Each slot has a valid bit.
- States:
  - EMPTY: main invalid.
  - ONE: main valid, skid invalid.
  - FULL: both valid.
- Accept: in_fire = in_valid & in_ready. Emit: out_fire = out_valid & out_ready.
- EMPTY:
  - in_fire loads main → ONE.
- ONE:
  - in_fire & out_fire: main ← input, stay ONE.
  - out_fire only → EMPTY.
  - in_fire only: input goes to skid → FULL.
- FULL:
  - in_ready=0.
  - out_fire: main ← skid, skid cleared → ONE.
- in_ready = !skid_valid. It never depends on out_ready in the same cycle.
- Ordering: strictly FIFO. Skid contents always follow main.
- flush=1 at an edge:
  - Both valid bits clear → EMPTY.
  - An in_fire in the same cycle is discarded. Flush has priority over accept and emit.
  - out_fire in the flush cycle still counts as consumed downstream.
- out_ctrl = main_ctrl & {CTRL_W{main_valid}}. out_data holds the last value when invalid; its value is don't-care.

## Timing
- Reset values: out_valid=0, out_data=0, out_ctrl=0, in_ready=1, internal valids=0, stall_cnt=0.
- Reset is asynchronous mid-operation. All entries are lost and no partial transfer completes.
- Latency: input accepted at edge N appears on out_* after edge N (1 cycle).
- Throughput: 1 entry/cycle while out_ready=1.
- After out_ready deasserts, at most one more entry is accepted (into skid); in_ready drops the following cycle.
- Recovery: in FULL, out_ready=1 for one cycle → in_ready=1 the next cycle.
- in_valid may assert with in_ready=0. No transfer occurs and the upstream must hold its data.

## Configuration
- PIPE_STALL_CNT_EN defined:
  - Port stall_cnt exists.
  - Increments by 1 every cycle with out_valid=1 & out_ready=0.
  - Saturates at all-ones. Cleared only by rst; flush does not clear it.
- Undefined: no stall_cnt port and no counter logic. Handshake behaviour is identical.

## Structure
- Shared package pipeline_pkg holds:
  - WORD_LEN and INSTRUCTION_LEN constants.
  - typedef wb_ctrl_t, a packed struct {sel_wb_mem, sel_wb_alu, rf_write_en} whose width sets CTRL_W at MEM/WB.
  - Enum stage_state_t {EMPTY, ONE, FULL}.
- One sub-module, pipe_slot: a register of {valid, ctrl, data} with load, clear and async reset. It is instantiated twice (main, skid).

## Test plan
- Reset then stream: rst pulse; in_valid=1, in_data=0x11,0x22,0x33 on consecutive cycles, out_ready=1 → out_data 0x11,0x22,0x33 one cycle later each, in_ready stays 1.
- Back-pressure:
  - Stimulus: out_ready=0 while sending 0xA1,0xA2,0xA3.
  - Accept/stall: 0xA1 and 0xA2 are accepted; in_ready=0 from the next cycle; 0xA3 is held upstream.
  - Release: out_ready=1 → 0xA1,0xA2,0xA3 emerge in order with no loss or duplication.
- Flush in FULL: flush=1 with in_valid=1 (0xFF) → next cycle out_valid=0, out_ctrl=0, in_ready=1; 0xFF is never emitted.
- Bubble control masking: in_ctrl=3'b111 with in_valid=0 → out_ctrl stays 3'b000.
- Async reset mid-stall: rst asserted between clock edges in FULL → out_valid=0 and in_ready=1 immediately, before the next edge.
- With PIPE_STALL_CNT_EN, CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles → stall_cnt=15 (saturated); a flush leaves it at 15.
